// File: rtl/fifo3_sync.sv
// Single-clock synchronous FIFO with occupancy count, almost-full/almost-empty
// thresholds, selectable FWFT read mode and sticky overflow/underflow flags.
module fifo3_sync #(
    parameter int DSIZE     = 8,
    parameter int ASIZE     = 4,
    parameter int FWFT      = 0,
    parameter int AFULL_TH  = 14,
    parameter int AEMPTY_TH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [DSIZE-1:0] wdata_i,
    input  logic             winc_i,
    output logic             wfull_o,
    output logic             wafull_o,
    input  logic             rinc_i,
    output logic [DSIZE-1:0] rdata_o,
    output logic             rvalid_o,
    output logic             rempty_o,
    output logic             raempty_o,
    output logic [ASIZE:0]   count_o,
    input  logic             clr_err_i,
    output logic             overflow_o,
    output logic             underflow_o
);

    localparam int              DEPTH    = 1 << ASIZE;
    localparam logic [ASIZE:0]  DEPTH_W  = (ASIZE+1)'(DEPTH);
    localparam logic [ASIZE:0]  AFULL_W  = (ASIZE+1)'(AFULL_TH);
    localparam logic [ASIZE:0]  AEMPTY_W = (ASIZE+1)'(AEMPTY_TH);
    localparam logic [ASIZE:0]  PTR_ONE  = (ASIZE+1)'(1);

    if (ASIZE < 1 || AEMPTY_TH < 0 || AEMPTY_TH >= AFULL_TH || AFULL_TH > DEPTH) begin : g_bad_params
        $error("fifo3_sync: illegal parameter set (need ASIZE>=1, 0<=AEMPTY_TH<AFULL_TH<=DEPTH)");
    end

    logic [DSIZE-1:0] mem_q [DEPTH];

    logic [ASIZE:0] wptr_q, wptr_d;
    logic [ASIZE:0] rptr_q, rptr_d;
    logic [ASIZE:0] count_q, count_d;
    logic           overflow_q, overflow_d;
    logic           underflow_q, underflow_d;

    logic             full_s;
    logic             empty_s;
    logic             we_s;
    logic             re_s;
    logic [ASIZE-1:0] waddr_s;
    logic [ASIZE-1:0] raddr_s;

    // Flags derive from the registered count only, never from winc/rinc.
    assign full_s   = (count_q == DEPTH_W);
    assign empty_s  = (count_q == {(ASIZE+1){1'b0}});
    assign we_s     = winc_i & ~full_s;
    assign re_s     = rinc_i & ~empty_s;
    assign waddr_s  = wptr_q[ASIZE-1:0];
    assign raddr_s  = rptr_q[ASIZE-1:0];

    assign wfull_o     = full_s;
    assign rempty_o    = empty_s;
    assign wafull_o    = (count_q >= AFULL_W);
    assign raempty_o   = (count_q <= AEMPTY_W);
    assign count_o     = count_q;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;

    // Next-state for pointers, occupancy and sticky error flags.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (we_s) begin
            wptr_d = wptr_q + PTR_ONE;
        end else begin
            wptr_d = wptr_q;
        end

        if (re_s) begin
            rptr_d = rptr_q + PTR_ONE;
        end else begin
            rptr_d = rptr_q;
        end

        case ({we_s, re_s})
            2'b10:   count_d = count_q + PTR_ONE;
            2'b01:   count_d = count_q - PTR_ONE;
            default: count_d = count_q;
        endcase

        // A set event in the same cycle as clr_err wins.
        overflow_d  = (winc_i & full_s)  | (overflow_q  & ~clr_err_i);
        underflow_d = (rinc_i & empty_s) | (underflow_q & ~clr_err_i);
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q      <= {(ASIZE+1){1'b0}};
            rptr_q      <= {(ASIZE+1){1'b0}};
            count_q     <= {(ASIZE+1){1'b0}};
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array write port; contents are intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (we_s && !rst_i) begin
            mem_q[waddr_s] <= wdata_i;
        end
    end

    if (FWFT == 0) begin : g_std
        logic [DSIZE-1:0] rdata_q;
        logic             rvalid_q;

        // Registered read port: data appears one edge after an accepted read.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                rdata_q  <= {DSIZE{1'b0}};
                rvalid_q <= 1'b0;
            end else if (re_s) begin
                rdata_q  <= mem_q[raddr_s];
                rvalid_q <= 1'b1;
            end else begin
                rdata_q  <= rdata_q;
                rvalid_q <= 1'b0;
            end
        end

        assign rdata_o  = rdata_q;
        assign rvalid_o = rvalid_q;
    end else begin : g_fwft
        // Head word is always presented; rinc only acknowledges it.
        assign rdata_o  = mem_q[raddr_s];
        assign rvalid_o = ~empty_s;
    end

endmodule

// File: tb/tb_fifo3_sync.sv
// Self-checking bench for fifo3_sync: one standard-mode and one FWFT instance,
// both compared cycle by cycle against queue-based reference models.
module tb_fifo3_sync;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] w0_data, w1_data;
    logic       w0, r0, c0, w1, r1, c1;

    logic       d0_wfull, d0_wafull, d0_rvalid, d0_rempty, d0_raempty, d0_ovf, d0_unf;
    logic [7:0] d0_rdata;
    logic [4:0] d0_count;
    logic       d1_wfull, d1_wafull, d1_rvalid, d1_rempty, d1_raempty, d1_ovf, d1_unf;
    logic [7:0] d1_rdata;
    logic [4:0] d1_count;

    fifo3_sync #(.DSIZE(8), .ASIZE(4), .FWFT(0), .AFULL_TH(14), .AEMPTY_TH(2)) dut_std (
        .clk_i(clk), .rst_i(rst), .wdata_i(w0_data), .winc_i(w0),
        .wfull_o(d0_wfull), .wafull_o(d0_wafull), .rinc_i(r0),
        .rdata_o(d0_rdata), .rvalid_o(d0_rvalid), .rempty_o(d0_rempty),
        .raempty_o(d0_raempty), .count_o(d0_count), .clr_err_i(c0),
        .overflow_o(d0_ovf), .underflow_o(d0_unf)
    );

    fifo3_sync #(.DSIZE(8), .ASIZE(4), .FWFT(1), .AFULL_TH(14), .AEMPTY_TH(2)) dut_fwft (
        .clk_i(clk), .rst_i(rst), .wdata_i(w1_data), .winc_i(w1),
        .wfull_o(d1_wfull), .wafull_o(d1_wafull), .rinc_i(r1),
        .rdata_o(d1_rdata), .rvalid_o(d1_rvalid), .rempty_o(d1_rempty),
        .raempty_o(d1_raempty), .count_o(d1_count), .clr_err_i(c1),
        .overflow_o(d1_ovf), .underflow_o(d1_unf)
    );

    // Reference model state
    logic [7:0] m0_q[$];
    logic [7:0] m1_q[$];
    bit         m0_ovf, m0_unf, m1_ovf, m1_unf;
    logic [7:0] m0_rdata;
    bit         m0_rvalid;

    int checks = 0;
    int errors = 0;

    function automatic logic [10:0] exp_status(int n, bit o, bit u);
        return {5'(n), 1'(n == 16), 1'(n >= 14), 1'(n == 0), 1'(n <= 2), 1'(o), 1'(u)};
    endfunction

    function automatic logic [10:0] std_status();
        return {d0_count, d0_wfull, d0_wafull, d0_rempty, d0_raempty, d0_ovf, d0_unf};
    endfunction

    function automatic logic [10:0] fw_status();
        return {d1_count, d1_wfull, d1_wafull, d1_rempty, d1_raempty, d1_ovf, d1_unf};
    endfunction

    // One clock: apply current inputs at the edge, update models, settle to negedge.
    task automatic tick();
        bit f0, e0, f1, e1;
        @(posedge clk);
        if (rst) begin
            m0_q.delete();
            m1_q.delete();
            m0_ovf = 1'b0; m0_unf = 1'b0; m1_ovf = 1'b0; m1_unf = 1'b0;
            m0_rdata = 8'h00; m0_rvalid = 1'b0;
        end else begin
            f0 = (m0_q.size() == 16); e0 = (m0_q.size() == 0);
            f1 = (m1_q.size() == 16); e1 = (m1_q.size() == 0);
            if (w0 && f0) m0_ovf = 1'b1; else if (c0) m0_ovf = 1'b0;
            if (r0 && e0) m0_unf = 1'b1; else if (c0) m0_unf = 1'b0;
            if (w1 && f1) m1_ovf = 1'b1; else if (c1) m1_ovf = 1'b0;
            if (r1 && e1) m1_unf = 1'b1; else if (c1) m1_unf = 1'b0;
            m0_rvalid = 1'b0;
            if (r0 && !e0) begin
                m0_rdata  = m0_q.pop_front();
                m0_rvalid = 1'b1;
            end
            if (w0 && !f0) m0_q.push_back(w0_data);
            if (r1 && !e1) void'(m1_q.pop_front());
            if (w1 && !f1) m1_q.push_back(w1_data);
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        w0 = 1'b0; r0 = 1'b0; c0 = 1'b0; w0_data = 8'h00;
        w1 = 1'b0; r1 = 1'b0; c1 = 1'b0; w1_data = 8'h00;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (std_status() !== {5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL reset_std_status: got %b expected %b", std_status(), 11'b00000_0_0_1_1_0_0);
        end
        checks++;
        if (fw_status() !== {5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL reset_fw_status: got %b expected %b", fw_status(), 11'b00000_0_0_1_1_0_0);
        end
        checks++;
        if (d0_rvalid !== 1'b0 || d0_rdata !== 8'h00) begin
            errors++; $display("FAIL reset_std_read: got rvalid=%b rdata=%h expected 0/00", d0_rvalid, d0_rdata);
        end
        checks++;
        if (d1_rvalid !== 1'b0) begin
            errors++; $display("FAIL reset_fw_rvalid: got %b expected 0", d1_rvalid);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            w0 = 1'b1; w0_data = 8'(i);
            tick();
            checks++;
            if (std_status() !== exp_status(i + 1, 1'b0, 1'b0)) begin
                errors++; $display("FAIL fill_status[%0d]: got %b expected %b", i, std_status(), exp_status(i + 1, 1'b0, 1'b0));
            end
        end
        w0 = 1'b0;
    endtask

    task automatic test_overflow();
        w0 = 1'b1; w0_data = 8'hAA;
        tick();
        w0 = 1'b0;
        checks++;
        if (std_status() !== {5'd16, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL overflow_set: got %b expected %b", std_status(), 11'b10000_1_1_0_0_1_0);
        end
        c0 = 1'b1;
        tick();
        c0 = 1'b0;
        checks++;
        if (d0_ovf !== 1'b0 || d0_count !== 5'd16) begin
            errors++; $display("FAIL overflow_clear: got ovf=%b count=%0d expected 0/16", d0_ovf, d0_count);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 16; i++) begin
            r0 = 1'b1;
            tick();
            checks++;
            if (d0_rvalid !== 1'b1 || d0_rdata !== 8'(i)) begin
                errors++; $display("FAIL drain_data[%0d]: got rvalid=%b rdata=%h expected 1/%h", i, d0_rvalid, d0_rdata, 8'(i));
            end
            checks++;
            if (std_status() !== exp_status(15 - i, 1'b0, 1'b0)) begin
                errors++; $display("FAIL drain_status[%0d]: got %b expected %b", i, std_status(), exp_status(15 - i, 1'b0, 1'b0));
            end
        end
        r0 = 1'b0;
        tick();
        checks++;
        if (d0_rvalid !== 1'b0 || d0_rdata !== 8'h0F) begin
            errors++; $display("FAIL drain_idle: got rvalid=%b rdata=%h expected 0/0f", d0_rvalid, d0_rdata);
        end
        r0 = 1'b1;
        tick();
        r0 = 1'b0;
        checks++;
        if (std_status() !== {5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1} || d0_rvalid !== 1'b0) begin
            errors++; $display("FAIL underflow_set: got %b rvalid=%b expected %b rvalid=0", std_status(), d0_rvalid, 11'b00000_0_0_1_1_0_1);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] base;
        c0 = 1'b1;
        tick();
        c0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            w0 = 1'b1; w0_data = 8'($urandom);
            tick();
        end
        base = 8'($urandom);
        for (int i = 0; i < 40; i++) begin
            w0 = 1'b1; r0 = 1'b1; w0_data = base + 8'(i);
            tick();
            checks++;
            if (d0_count !== 5'd5 || d0_rvalid !== m0_rvalid || d0_rdata !== m0_rdata) begin
                errors++; $display("FAIL b2b[%0d]: got count=%0d rvalid=%b rdata=%h expected 5/%b/%h",
                                   i, d0_count, d0_rvalid, d0_rdata, m0_rvalid, m0_rdata);
            end
        end
        w0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (d0_rvalid !== 1'b1 || d0_rdata !== base + 8'(35 + i)) begin
                errors++; $display("FAIL b2b_tail[%0d]: got rvalid=%b rdata=%h expected 1/%h", i, d0_rvalid, d0_rdata, base + 8'(35 + i));
            end
        end
        r0 = 1'b0;
        tick();
    endtask

    task automatic test_fwft();
        checks++;
        if (d1_rvalid !== 1'b0 || d1_rempty !== 1'b1) begin
            errors++; $display("FAIL fwft_start: got rvalid=%b rempty=%b expected 0/1", d1_rvalid, d1_rempty);
        end
        w1 = 1'b1; w1_data = 8'h5C;
        tick();
        w1 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (d1_rvalid !== 1'b1 || d1_rdata !== 8'h5C || d1_count !== 5'd1) begin
                errors++; $display("FAIL fwft_head[%0d]: got rvalid=%b rdata=%h count=%0d expected 1/5c/1", i, d1_rvalid, d1_rdata, d1_count);
            end
            tick();
        end
        r1 = 1'b1;
        tick();
        r1 = 1'b0;
        checks++;
        if (d1_rempty !== 1'b1 || d1_rvalid !== 1'b0 || d1_unf !== 1'b0) begin
            errors++; $display("FAIL fwft_pop: got rempty=%b rvalid=%b unf=%b expected 1/0/0", d1_rempty, d1_rvalid, d1_unf);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 9; i++) begin
            w0 = 1'b1; w0_data = 8'($urandom_range(0, 99));
            tick();
        end
        checks++;
        if (d0_count !== 5'd9) begin
            errors++; $display("FAIL mid_prefill: got count=%0d expected 9", d0_count);
        end
        w0 = 1'b1; r0 = 1'b1; w0_data = 8'hEE; rst = 1'b1;
        tick();
        rst = 1'b0; w0 = 1'b0; r0 = 1'b0;
        checks++;
        if (std_status() !== {5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0} || d0_rvalid !== 1'b0 || d0_rdata !== 8'h00) begin
            errors++; $display("FAIL mid_reset: got %b rvalid=%b rdata=%h expected %b 0 00",
                               std_status(), d0_rvalid, d0_rdata, 11'b00000_0_0_1_1_0_0);
        end
        w0 = 1'b1; w0_data = 8'h77;
        tick();
        w0 = 1'b0; r0 = 1'b1;
        tick();
        r0 = 1'b0;
        checks++;
        if (d0_rvalid !== 1'b1 || d0_rdata !== 8'h77 || d0_count !== 5'd0) begin
            errors++; $display("FAIL mid_fresh: got rvalid=%b rdata=%h count=%0d expected 1/77/0", d0_rvalid, d0_rdata, d0_count);
        end
    endtask

    task automatic test_random();
        int wprob;
        for (int i = 0; i < 600; i++) begin
            wprob = ((i / 100) % 2 == 0) ? 75 : 25;
            w0 = ($urandom_range(0, 99) < wprob);
            r0 = ($urandom_range(0, 99) < 100 - wprob);
            c0 = ($urandom_range(0, 15) == 0);
            w0_data = 8'($urandom);
            w1 = ($urandom_range(0, 99) < wprob);
            r1 = ($urandom_range(0, 99) < 100 - wprob);
            c1 = ($urandom_range(0, 15) == 0);
            w1_data = 8'($urandom);
            tick();
            checks++;
            if (std_status() !== exp_status(m0_q.size(), m0_ovf, m0_unf)) begin
                errors++; $display("FAIL rand_std_status[%0d]: got %b expected %b", i, std_status(), exp_status(m0_q.size(), m0_ovf, m0_unf));
            end
            checks++;
            if (d0_rvalid !== m0_rvalid || d0_rdata !== m0_rdata) begin
                errors++; $display("FAIL rand_std_read[%0d]: got %b/%h expected %b/%h", i, d0_rvalid, d0_rdata, m0_rvalid, m0_rdata);
            end
            checks++;
            if (fw_status() !== exp_status(m1_q.size(), m1_ovf, m1_unf)) begin
                errors++; $display("FAIL rand_fw_status[%0d]: got %b expected %b", i, fw_status(), exp_status(m1_q.size(), m1_ovf, m1_unf));
            end
            checks++;
            if (d1_rvalid !== (m1_q.size() != 0) || (m1_q.size() != 0 && d1_rdata !== m1_q[0])) begin
                errors++; $display("FAIL rand_fw_head[%0d]: got %b/%h expected %b/%h", i, d1_rvalid, d1_rdata,
                                   (m1_q.size() != 0), (m1_q.size() != 0) ? m1_q[0] : 8'h00);
            end
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_back_to_back();
        test_fwft();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
